// File: rtl/iccm_sram_arbiter.sv
// Single-port ICCM SRAM arbiter between the core fetch port (F, read-only)
// and the programming loader (L, read/write). It sequences RUN -> DRAIN ->
// PROG hand-over, keeps at most one access per cycle, and routes each read
// return to the requester that issued it.
module iccm_sram_arbiter #(
  parameter int AW       = 12,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            prog_mode_i,
  // fetch requester
  input  logic            f_req_i,
  input  logic [AW-1:0]   f_addr_i,
  output logic            f_gnt_o,
  output logic            f_rvalid_o,
  output logic [DW-1:0]   f_rdata_o,
  // loader requester
  input  logic            l_req_i,
  input  logic            l_we_i,
  input  logic [AW-1:0]   l_addr_i,
  input  logic [DW-1:0]   l_wdata_i,
  input  logic [DW/8-1:0] l_wmask_i,
  output logic            l_gnt_o,
  output logic            l_rvalid_o,
  output logic [DW-1:0]   l_rdata_o,
  // status
  output logic            prog_active_o,
  output logic [AW:0]     wr_count_o,
  // SRAM macro pins
  output logic            csb_o,
  output logic            we_o,
  output logic [AW-1:0]   addr_o,
  output logic [DW-1:0]   wdata_o,
  output logic [DW/8-1:0] wmask_o,
  input  logic [DW-1:0]   rdata_i
);

  localparam int MW  = DW / 8;
  localparam int WCW = $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] WAIT_LIM = WCW'(MAX_WAIT);
  localparam logic [AW:0]    WR_SAT   = {1'b1, {AW{1'b0}}};

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_PROG  = 2'd2
  } state_e;

  state_e          state_q,     state_d;
  logic            last_l_q,    last_l_d;     // 1: L won the most recent grant
  logic [WCW-1:0]  f_wait_q,    f_wait_d;
  logic [WCW-1:0]  l_wait_q,    l_wait_d;
  logic            tag_valid_q, tag_valid_d;  // a read is in flight
  logic            tag_l_q,     tag_l_d;      // in-flight read belongs to L
  logic [AW:0]     wr_count_q,  wr_count_d;
  logic [AW-1:0]   addr_q,      addr_d;
  logic [DW-1:0]   wdata_q,     wdata_d;
  logic [MW-1:0]   wmask_q,     wmask_d;

  logic f_gnt, l_gnt, arb_cycle, f_force, l_force;

  // Arbitration: choose at most one winner from state, mode request and fairness history.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    f_gnt     = 1'b0;
    l_gnt     = 1'b0;
    // A cycle where prog_mode_i disagrees with the current mode is a transition
    // cycle and issues no grants; reset also suppresses all grants.
    arb_cycle = (state_q == ST_RUN) && !prog_mode_i && !rst_i;
    f_force   = (f_wait_q >= WAIT_LIM);
    l_force   = (l_wait_q >= WAIT_LIM);
    if (arb_cycle) begin
      if (f_req_i && l_req_i) begin
        if (f_force && !l_force)      f_gnt = 1'b1;
        else if (l_force && !f_force) l_gnt = 1'b1;
        else if (last_l_q)            f_gnt = 1'b1;
        else                          l_gnt = 1'b1;
      end else begin
        f_gnt = f_req_i;
        l_gnt = l_req_i;
      end
    end else if ((state_q == ST_PROG) && prog_mode_i && !rst_i) begin
      l_gnt = l_req_i;
    end
  end

  // Next-state logic: mode sequencing, fairness counters, read tag, write count, pin hold.
  always_comb begin
    state_d     = state_q;
    last_l_d    = last_l_q;
    f_wait_d    = f_wait_q;
    l_wait_d    = l_wait_q;
    wr_count_d  = wr_count_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wmask_d     = wmask_q;
    tag_valid_d = f_gnt | (l_gnt & ~l_we_i);
    tag_l_d     = l_gnt;

    if (f_gnt)      last_l_d = 1'b0;
    else if (l_gnt) last_l_d = 1'b1;

    // Waits only accumulate on genuine arbitration losses in run mode.
    if (f_gnt)                                            f_wait_d = '0;
    else if (arb_cycle && f_req_i && f_wait_q != WAIT_LIM) f_wait_d = f_wait_q + 1'b1;
    if (l_gnt)                                            l_wait_d = '0;
    else if (arb_cycle && l_req_i && l_wait_q != WAIT_LIM) l_wait_d = l_wait_q + 1'b1;

    // The fetch port has no write data, so its accesses present zero data/mask.
    if (l_gnt) begin
      addr_d  = l_addr_i;
      wdata_d = l_wdata_i;
      wmask_d = l_wmask_i;
    end else if (f_gnt) begin
      addr_d  = f_addr_i;
      wdata_d = '0;
      wmask_d = '0;
    end

    if ((state_q == ST_PROG) && l_gnt && l_we_i && (wr_count_q != WR_SAT))
      wr_count_d = wr_count_q + 1'b1;

    unique case (state_q)
      ST_RUN:   if (prog_mode_i) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (!tag_valid_q) begin
          if (prog_mode_i) begin
            state_d    = ST_PROG;
            wr_count_d = '0;
          end else begin
            state_d    = ST_RUN;
          end
        end
      end
      ST_PROG:  if (!prog_mode_i) state_d = ST_DRAIN;
      default:  state_d = ST_RUN;
    endcase
  end

  // State register with asynchronous active-high reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      // NOTE: non-blocking assignments only in clocked blocks so every flop samples pre-edge values.
      state_q     <= ST_RUN;
      last_l_q    <= 1'b1;
      f_wait_q    <= '0;
      l_wait_q    <= '0;
      tag_valid_q <= 1'b0;
      tag_l_q     <= 1'b0;
      wr_count_q  <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wmask_q     <= '0;
    end else begin
      state_q     <= state_d;
      last_l_q    <= last_l_d;
      f_wait_q    <= f_wait_d;
      l_wait_q    <= l_wait_d;
      tag_valid_q <= tag_valid_d;
      tag_l_q     <= tag_l_d;
      wr_count_q  <= wr_count_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
    end
  end

  assign f_gnt_o       = f_gnt;
  assign l_gnt_o       = l_gnt;
  assign csb_o         = ~(f_gnt | l_gnt);
  assign we_o          = ~(l_gnt & l_we_i);
  assign addr_o        = addr_d;
  assign wdata_o       = wdata_d;
  assign wmask_o       = wmask_d;

  assign f_rvalid_o    = tag_valid_q & ~tag_l_q;
  assign l_rvalid_o    = tag_valid_q &  tag_l_q;
  assign f_rdata_o     = f_rvalid_o ? rdata_i : '0;
  assign l_rdata_o     = l_rvalid_o ? rdata_i : '0;

  assign prog_active_o = (state_q == ST_PROG);
  assign wr_count_o    = wr_count_q;

endmodule

// File: tb/tb_iccm_sram_arbiter.sv
// Bench for iccm_sram_arbiter: a behavioural SRAM on the macro pins, a
// transaction-level model of the arbiter checked every cycle, and directed
// scenarios with hand-computed literal expectations.
module tb_iccm_sram_arbiter;

  localparam int AW       = 12;
  localparam int DW       = 32;
  localparam int MW       = DW / 8;
  localparam int MAX_WAIT = 4;
  localparam int DEPTH    = 1 << AW;
  localparam int P_RUN    = 0;
  localparam int P_DRAIN  = 1;
  localparam int P_PROG   = 2;

  logic          clk_i;
  logic          rst_i;
  logic          prog_mode_i;
  logic          f_req_i;
  logic [AW-1:0] f_addr_i;
  logic          f_gnt_o, f_rvalid_o;
  logic [DW-1:0] f_rdata_o;
  logic          l_req_i, l_we_i;
  logic [AW-1:0] l_addr_i;
  logic [DW-1:0] l_wdata_i;
  logic [MW-1:0] l_wmask_i;
  logic          l_gnt_o, l_rvalid_o;
  logic [DW-1:0] l_rdata_o;
  logic          prog_active_o;
  logic [AW:0]   wr_count_o;
  logic          csb_o, we_o;
  logic [AW-1:0] addr_o;
  logic [DW-1:0] wdata_o;
  logic [MW-1:0] wmask_o;
  logic [DW-1:0] rdata_i;

  int n_cmp = 0;
  int n_err = 0;
  bit model_en = 1'b0;

  logic [DW-1:0] sram    [DEPTH];
  logic [DW-1:0] exp_mem [DEPTH];

  iccm_sram_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .prog_mode_i(prog_mode_i),
    .f_req_i(f_req_i), .f_addr_i(f_addr_i), .f_gnt_o(f_gnt_o),
    .f_rvalid_o(f_rvalid_o), .f_rdata_o(f_rdata_o),
    .l_req_i(l_req_i), .l_we_i(l_we_i), .l_addr_i(l_addr_i),
    .l_wdata_i(l_wdata_i), .l_wmask_i(l_wmask_i), .l_gnt_o(l_gnt_o),
    .l_rvalid_o(l_rvalid_o), .l_rdata_o(l_rdata_o),
    .prog_active_o(prog_active_o), .wr_count_o(wr_count_o),
    .csb_o(csb_o), .we_o(we_o), .addr_o(addr_o), .wdata_o(wdata_o),
    .wmask_o(wmask_o), .rdata_i(rdata_i)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1);
  end

  function automatic logic [DW-1:0] init_word(input int i);
    if (i == 16) return 32'hDEADBEEF;
    return 32'hC0DE_0000 | DW'(i);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural single-port SRAM driven by the macro pins.
  always @(posedge clk_i) begin
    if (!csb_o) begin
      if (!we_o) begin
        for (int b = 0; b < MW; b++)
          if (wmask_o[b]) sram[addr_o][8*b +: 8] <= wdata_o[8*b +: 8];
      end else begin
        rdata_i <= sram[addr_o];
      end
    end
  end

  // ---------------- transaction-level model ----------------
  int            m_phase;
  bit            m_last_l;
  int            m_fw, m_lw;
  bit            m_ret_v, m_ret_l;
  logic [DW-1:0] m_ret_d;
  logic [AW:0]   m_wr;
  bit            m_hold_known;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [MW-1:0] m_wmask;

  task automatic model_reset();
    m_phase      = P_RUN;
    m_last_l     = 1'b1;
    m_fw         = 0;
    m_lw         = 0;
    m_ret_v      = 1'b0;
    m_ret_l      = 1'b0;
    m_ret_d      = '0;
    m_wr         = '0;
    m_hold_known = 1'b0;
  endtask

  // Compare every cycle on the falling edge, then advance the model across the next rising edge.
  always @(negedge clk_i) begin : model_p
    bit            gf, gl, arb, nv;
    logic [DW-1:0] nd;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic [MW-1:0] e_wmask;
    if (model_en) begin
      if (rst_i) begin
        model_reset();
        check("rst_f_gnt", f_gnt_o, 0);
        check("rst_l_gnt", l_gnt_o, 0);
        check("rst_csb", csb_o, 1);
        check("rst_we", we_o, 1);
        check("rst_f_rvalid", f_rvalid_o, 0);
        check("rst_l_rvalid", l_rvalid_o, 0);
        check("rst_prog_active", prog_active_o, 0);
        check("rst_wr_count", wr_count_o, 0);
      end else begin
        gf  = 1'b0;
        gl  = 1'b0;
        arb = (m_phase == P_RUN) && !prog_mode_i;
        if (arb) begin
          if (f_req_i && l_req_i) begin
            if (m_fw >= MAX_WAIT && m_lw < MAX_WAIT)      gf = 1'b1;
            else if (m_lw >= MAX_WAIT && m_fw < MAX_WAIT) gl = 1'b1;
            else if (m_last_l)                            gf = 1'b1;
            else                                          gl = 1'b1;
          end else begin
            gf = f_req_i;
            gl = l_req_i;
          end
        end else if (m_phase == P_PROG && prog_mode_i) begin
          gl = l_req_i;
        end

        e_addr  = gl ? l_addr_i  : (gf ? f_addr_i : m_addr);
        e_wdata = gl ? l_wdata_i : (gf ? '0 : m_wdata);
        e_wmask = gl ? l_wmask_i : (gf ? '0 : m_wmask);

        check("m_f_gnt", f_gnt_o, gf);
        check("m_l_gnt", l_gnt_o, gl);
        check("m_csb", csb_o, !(gf || gl));
        check("m_we", we_o, !(gl && l_we_i));
        if (gf || gl || m_hold_known) begin
          check("m_addr", addr_o, e_addr);
          check("m_wdata", wdata_o, e_wdata);
          check("m_wmask", wmask_o, e_wmask);
        end
        check("m_f_rvalid", f_rvalid_o, m_ret_v && !m_ret_l);
        check("m_f_rdata", f_rdata_o, (m_ret_v && !m_ret_l) ? m_ret_d : '0);
        check("m_l_rvalid", l_rvalid_o, m_ret_v && m_ret_l);
        check("m_l_rdata", l_rdata_o, (m_ret_v && m_ret_l) ? m_ret_d : '0);
        check("m_prog_active", prog_active_o, m_phase == P_PROG);
        check("m_wr_count", wr_count_o, m_wr);

        // advance: the access itself
        nv = gf || (gl && !l_we_i);
        nd = exp_mem[gl ? l_addr_i : f_addr_i];
        if (gl && l_we_i)
          for (int b = 0; b < MW; b++)
            if (l_wmask_i[b]) exp_mem[l_addr_i][8*b +: 8] = l_wdata_i[8*b +: 8];
        if (gf || gl) begin
          m_hold_known = 1'b1;
          m_addr       = e_addr;
          m_wdata      = e_wdata;
          m_wmask      = e_wmask;
        end
        // fairness history
        if (gf) m_last_l = 1'b0;
        if (gl) m_last_l = 1'b1;
        if (gf) m_fw = 0; else if (arb && f_req_i && m_fw < MAX_WAIT) m_fw++;
        if (gl) m_lw = 0; else if (arb && l_req_i && m_lw < MAX_WAIT) m_lw++;
        // program-mode write count
        if (m_phase == P_PROG && gl && l_we_i && m_wr != (AW+1)'(DEPTH)) m_wr = m_wr + 1'b1;
        // mode sequencing uses the read in flight during this cycle
        case (m_phase)
          P_RUN:   if (prog_mode_i) m_phase = P_DRAIN;
          P_DRAIN: if (!m_ret_v) begin
                     if (prog_mode_i) begin
                       m_phase = P_PROG;
                       m_wr    = '0;
                     end else begin
                       m_phase = P_RUN;
                     end
                   end
          default: if (!prog_mode_i) m_phase = P_DRAIN;
        endcase
        m_ret_v = nv;
        m_ret_l = gl;
        m_ret_d = nd;
      end
    end
  end

  task automatic next();
    @(posedge clk_i);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      sram[i]    = init_word(i);
      exp_mem[i] = init_word(i);
    end
    rst_i       = 1'b0;
    prog_mode_i = 1'b0;
    f_req_i     = 1'b0;
    f_addr_i    = '0;
    l_req_i     = 1'b0;
    l_we_i      = 1'b0;
    l_addr_i    = '0;
    l_wdata_i   = '0;
    l_wmask_i   = '0;
    model_reset();
    #1 rst_i = 1'b1;
    #1 model_en = 1'b1;
    check("reset_csb", csb_o, 1);
    check("reset_we", we_o, 1);
    check("reset_prog_active", prog_mode_i | prog_active_o, 0);
    check("reset_wr_count", wr_count_o, 0);
    #10 rst_i = 1'b0;

    // T1: fetch alone reads 0x010
    next(); f_req_i = 1'b1; f_addr_i = 12'h010; #1;
    check("t1_f_gnt", f_gnt_o, 1);
    check("t1_csb", csb_o, 0);
    check("t1_we", we_o, 1);
    check("t1_addr", addr_o, 12'h010);
    next(); f_req_i = 1'b0; #1;
    check("t1_f_rvalid", f_rvalid_o, 1);
    check("t1_f_rdata", f_rdata_o, 32'hDEADBEEF);
    check("t1_l_rvalid", l_rvalid_o, 0);

    // T2: loader alone once, then both request continuously -> F,L,F,L...
    next(); l_req_i = 1'b1; l_we_i = 1'b0; l_addr_i = 12'h100; #1;
    check("t2_l_alone_gnt", l_gnt_o, 1);
    for (int k = 0; k < 8; k++) begin
      next();
      f_req_i  = 1'b1; f_addr_i = 12'(12'h020 + k);
      l_req_i  = 1'b1; l_we_i   = 1'b0; l_addr_i = 12'(12'h200 + k);
      #1;
      check("t2_f_gnt", f_gnt_o, (k % 2) == 0);
      check("t2_l_gnt", l_gnt_o, (k % 2) == 1);
    end
    next(); f_req_i = 1'b0; l_req_i = 1'b0; #1;
    check("t2_last_l_rvalid", l_rvalid_o, 1);
    check("t2_last_l_rdata", l_rdata_o, 32'hC0DE0207);

    // Run-mode byte-masked loader write, then read back
    next(); l_req_i = 1'b1; l_we_i = 1'b1; l_addr_i = 12'h030;
    l_wdata_i = 32'h11223344; l_wmask_i = 4'b0101; #1;
    check("rw_we", we_o, 0);
    next(); l_we_i = 1'b0; #1;
    next(); l_req_i = 1'b0; #1;
    check("rw_l_rdata", l_rdata_o, 32'hC0220044);

    // T3: prog_mode rises one cycle after an F read is granted
    next(); f_req_i = 1'b1; f_addr_i = 12'h040; #1;
    check("t3_f_gnt", f_gnt_o, 1);
    next(); prog_mode_i = 1'b1; f_addr_i = 12'h041; #1;
    check("t3_transition_no_gnt", f_gnt_o, 0);
    check("t3_f_rvalid", f_rvalid_o, 1);
    check("t3_f_rdata", f_rdata_o, 32'hC0DE0040);
    next(); #1;
    check("t3_drain_csb", csb_o, 1);
    check("t3_drain_prog_active", prog_active_o, 0);
    next(); #1;
    check("t3_prog_active", prog_active_o, 1);
    check("t3_prog_no_f_gnt", f_gnt_o, 0);

    // T4: five full-word writes to 0..4, then read addr 2
    for (int i = 0; i < 5; i++) begin
      next();
      l_req_i = 1'b1; l_we_i = 1'b1; l_addr_i = 12'(i);
      l_wdata_i = 32'h5A00_0000 + DW'(i); l_wmask_i = 4'hF;
      #1;
      check("t4_wr_gnt", l_gnt_o, 1);
      check("t4_wr_we", we_o, 0);
      check("t4_wr_no_f_gnt", f_gnt_o, 0);
    end
    next(); l_we_i = 1'b0; l_addr_i = 12'h002; #1;
    check("t4_wr_count", wr_count_o, 5);
    check("t4_rd_we", we_o, 1);
    next(); l_req_i = 1'b0; #1;
    check("t4_l_rvalid", l_rvalid_o, 1);
    check("t4_l_rdata", l_rdata_o, 32'h5A000002);

    // T5: leave program mode with F pending
    next(); prog_mode_i = 1'b0; f_addr_i = 12'h050; #1;
    check("t5_exit_no_gnt", f_gnt_o, 0);
    next(); #1;
    check("t5_drain_no_gnt", f_gnt_o, 0);
    next(); #1;
    check("t5_run_f_gnt", f_gnt_o, 1);
    check("t5_wr_count_hold", wr_count_o, 5);
    next(); f_req_i = 1'b0; #1;
    check("t5_f_rdata", f_rdata_o, 32'hC0DE0050);

    // T6: re-enter PROG, write once, start a read, then reset mid-flight
    next(); prog_mode_i = 1'b1; #1;
    next(); #1;
    next(); l_req_i = 1'b1; l_we_i = 1'b1; l_addr_i = 12'h007;
    l_wdata_i = 32'h0BADF00D; l_wmask_i = 4'hF; #1;
    check("t6_entry_wr_count", wr_count_o, 0);
    next(); l_we_i = 1'b0; l_addr_i = 12'h001; #1;
    check("t6_rd_gnt", l_gnt_o, 1);
    check("t6_wr_count", wr_count_o, 1);
    @(posedge clk_i); #3;
    rst_i = 1'b1; l_req_i = 1'b0; prog_mode_i = 1'b0; #1;
    check("t6_rst_csb", csb_o, 1);
    check("t6_rst_we", we_o, 1);
    check("t6_rst_l_rvalid", l_rvalid_o, 0);
    check("t6_rst_prog_active", prog_active_o, 0);
    check("t6_rst_wr_count", wr_count_o, 0);
    next();
    check("t6_rst_next_l_rvalid", l_rvalid_o, 0);
    #1 rst_i = 1'b0;
    next(); f_req_i = 1'b1; f_addr_i = 12'h060; #1;
    check("t6_run_f_gnt", f_gnt_o, 1);
    next(); f_req_i = 1'b0; #1;
    check("t6_run_f_rdata", f_rdata_o, 32'hC0DE0060);
    next(); next();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/iccm_sram_arbiter.md
Name: iccm_sram_arbiter

Overview:
- Shares the single-port instruction SRAM macro between two requesters:
  - the core fetch port (requester F, read-only, fed by the TL-UL SRAM adapter);
  - the ICCM programming loader (requester L, read/write, used for boot image load and readback verify).
- Sequences the hand-over between program mode and run mode, drains in-flight reads, and generates per-requester read-valid strobes.
- Sits between both requesters and the SRAM pins, with the macro's active-low csb/we.

Parameters:
- AW, 12, SRAM word address width.
- DW, 32, data width.
- MAX_WAIT, 4, max consecutive cycles a pending requester may lose arbitration in run mode before it is forced priority.

Ports:
- Clocking and reset: one clock `clk_i`; reset `rst_i` is asynchronous and active-high.
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- prog_mode_i  in  1  1 = program mode requested, 0 = run mode requested.
- f_req_i  in  1  fetch read request.
- f_addr_i  in  AW  fetch word address.
- f_gnt_o  out  1  fetch request accepted this cycle.
- f_rvalid_o  out  1  fetch read data valid.
- f_rdata_o  out  DW  fetch read data.
- l_req_i  in  1  loader request.
- l_we_i  in  1  loader write (1) / read (0).
- l_addr_i  in  AW  loader word address.
- l_wdata_i  in  DW  loader write data.
- l_wmask_i  in  DW/8  loader byte enables.
- l_gnt_o  out  1  loader request accepted.
- l_rvalid_o  out  1  loader read data valid.
- l_rdata_o  out  DW  loader read data.
- prog_active_o  out  1  arbiter is in PROG state.
- wr_count_o  out  AW+1  loader writes accepted since entering PROG.
- csb_o  out  1  SRAM chip select, active-low.
- we_o  out  1  SRAM write enable, active-low.
- addr_o  out  AW  SRAM address.
- wdata_o  out  DW  SRAM write data.
- wmask_o  out  DW/8  SRAM byte mask.
- rdata_i  in  DW  SRAM read data, valid one cycle after a read access.

Behaviour:
- States: RUN, DRAIN, PROG. Reset enters RUN.
- Reset values:
  - csb_o=1, we_o=1, gnts=0, rvalids=0, prog_active_o=0, wr_count_o=0;
  - last-winner pointer = L, so F wins the first tie; wait counters = 0.
- At most one SRAM access per cycle. Grant is combinational from req and state.
- An SRAM access happens in the same cycle as its gnt:
  - csb_o=0;
  - we_o = ~(l_we_i) for L, we_o=1 for F;
  - addr/wdata/wmask driven from the winner.
- With no grant: csb_o=1, we_o=1, addr/wdata/wmask hold their last values.
- Read return: a granted read registers a 1-bit owner tag.
  - The next cycle pulses the owner's rvalid, and its rdata = rdata_i.
  - The non-owner's rdata is 0.
  - A granted write produces no rvalid.
- RUN:
  - Both F and L are eligible.
  - If only one requests, it is granted.
  - If both request, round-robin: the one that did not win last is granted, unless its wait counter ≥ MAX_WAIT, in which case it is granted regardless.
  - Each wait counter increments per cycle its requester is pending and not granted, and clears on grant.
  - prog_mode_i=1 → DRAIN. No grants are issued in the transition cycle.
- DRAIN:
  - No new grants.
  - Stays until no read is in flight (tag register empty), at most 1 cycle.
  - Then → PROG if prog_mode_i=1, else → RUN. The return to RUN handles prog_mode dropping during drain.
- PROG:
  - f_gnt_o=0 always; only L is granted.
  - prog_active_o=1.
  - wr_count_o clears on entry and increments on each granted L write, saturating at 2^AW.
  - prog_mode_i=0 → DRAIN, then → RUN. wr_count_o holds its value after exit until the next PROG entry.
- Simultaneous events:
  - A prog_mode_i change in a cycle with pending reqs: the requests are not granted that cycle and the state changes.
  - The registered read in flight still returns its rvalid in DRAIN.
- Reset mid-operation: asynchronous return to reset values. An in-flight rvalid is dropped.

Test Plan:
- Run mode, F alone reads addr 0x010 (SRAM returns 0xDEADBEEF) → f_gnt_o=1 in cycle 0; csb_o=0, we_o=1, addr_o=0x010; f_rvalid_o=1 with f_rdata_o=0xDEADBEEF in cycle 1; l_rvalid_o=0.
- Run mode, F and L request continuously, L reads → grants alternate F,L,F,L starting with F; each rvalid is routed to the correct owner; no wait counter reaches MAX_WAIT.
- Assert prog_mode_i one cycle after an F read is granted → the F rvalid still arrives, no grant during DRAIN, prog_active_o=1 the following cycle, f_gnt_o=0 despite f_req_i=1.
- PROG: L writes 5 words (wmask 0xF, addr 0..4) then reads addr 2 → we_o=0 on the 5 writes, wr_count_o=5, l_rvalid_o returns the data written to addr 2, we_o=1 on the read.
- Deassert prog_mode_i → DRAIN then RUN; a pending F request is granted on the first RUN cycle; wr_count_o holds 5.
- Assert rst_i asynchronously mid-PROG with a read in flight → csb_o=1, we_o=1, state RUN, no rvalid next cycle, wr_count_o=0.
